// File: rtl/decode_hazard_stage_if.sv
// Fetch/execute/write-back bundle around the decode stage, plus the control
// word and stage payload types carried on regs_out.
interface decode_hazard_stage_if;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       alu_src_imm;
        logic       alu_src_pc;
        logic [2:0] imm_sel;
        logic [3:0] alu_op;
        logic       illegal;
    } ctrl_word;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] i_imm;
        logic [31:0] s_imm;
        logic [31:0] b_imm;
        logic [31:0] u_imm;
        logic [31:0] j_imm;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        ctrl_word    ctrl;
        logic [31:0] alu;
        logic        br;
    } stage_regs;

    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        ex_ready;
    logic        flush;
    logic        wb_load;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    stage_regs   regs_out;
    logic [31:0] stall_count;

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready, flush, wb_load, wb_rd, wb_data,
        output id_ready, regs_out, stall_count
    );

    modport master (
        output if_valid, if_instr, if_pc, ex_ready, flush, wb_load, wb_rd, wb_data,
        input  id_ready, regs_out, stall_count
    );

endinterface

// File: rtl/decode_hazard_stage.sv
// RV32I/RV32E decode stage: field split, control ROM, bypassed register file,
// valid/ready pipeline register with flush and a single-bubble load-use stall.
module decode_hazard_stage #(
    parameter int NREGS          = 32,
    parameter bit BYPASS         = 1'b1,
    parameter bit LOAD_USE_STALL = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    decode_hazard_stage_if.slave bus
);

    localparam int         IDX_W     = $clog2(NREGS);
    localparam logic [5:0] NREGS_LIM = 6'(NREGS);

    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_sel_e;

    // ---------------- field split and immediates ----------------
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;

    assign instr  = bus.if_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign i_imm = {{20{instr[31]}}, instr[31:20]};
    assign s_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign b_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};
    assign j_imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // ---------------- control ROM ----------------
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     alu_src_imm;
    logic     alu_src_pc;
    logic     illegal;
    alu_op_e  alu_op;
    imm_sel_e imm_sel;

    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt,
                                               input logic is_reg);
        case (f3)
            3'd0:    return (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        branch      = 1'b0;
        jump        = 1'b0;
        alu_src_imm = 1'b0;
        alu_src_pc  = 1'b0;
        illegal     = 1'b0;
        alu_op      = ALU_ADD;
        imm_sel     = IMM_NONE;
        case (opcode)
            OPC_LUI: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                imm_sel     = IMM_U;
                alu_op      = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                alu_src_pc  = 1'b1;
                imm_sel     = IMM_U;
            end
            OPC_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                alu_src_pc = 1'b1;
                imm_sel    = IMM_J;
            end
            OPC_JALR: begin
                reg_write   = 1'b1;
                jump        = 1'b1;
                alu_src_imm = 1'b1;
                imm_sel     = IMM_I;
                illegal     = (funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                branch  = 1'b1;
                imm_sel = IMM_B;
                case (funct3)
                    3'd0, 3'd1: alu_op = ALU_SUB;
                    3'd4, 3'd5: alu_op = ALU_SLT;
                    3'd6, 3'd7: alu_op = ALU_SLTU;
                    default:    illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                reg_write   = 1'b1;
                mem_read    = 1'b1;
                alu_src_imm = 1'b1;
                imm_sel     = IMM_I;
                illegal     = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
            end
            OPC_STORE: begin
                mem_write   = 1'b1;
                alu_src_imm = 1'b1;
                imm_sel     = IMM_S;
                illegal     = (funct3 > 3'd2);
            end
            OPC_OP_IMM: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                imm_sel     = IMM_I;
                alu_op      = alu_from_funct(funct3, funct7[5], 1'b0);
                illegal     = ((funct3 == 3'd1) && (funct7 != 7'b0000000)) ||
                              ((funct3 == 3'd5) && (funct7 != 7'b0000000) &&
                               (funct7 != 7'b0100000));
            end
            OPC_OP: begin
                reg_write = 1'b1;
                alu_op    = alu_from_funct(funct3, funct7[5], 1'b1);
                illegal   = !((funct7 == 7'b0000000) ||
                              ((funct7 == 7'b0100000) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
            end
            OPC_MISC_MEM, OPC_SYSTEM: ;
            default: illegal = 1'b1;
        endcase
        // An illegal word must not have architectural side effects downstream.
        if (illegal) begin
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            branch    = 1'b0;
            jump      = 1'b0;
        end
    end

    // ---------------- register file with write-back bypass ----------------
    logic [31:0] rf [NREGS];
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    function automatic logic in_range(input logic [4:0] idx);
        return {1'b0, idx} < NREGS_LIM;
    endfunction

    function automatic logic [31:0] read_reg(input logic [4:0] idx);
        if (idx == 5'd0 || !in_range(idx))
            return 32'd0;
        else if (BYPASS && bus.wb_load && (bus.wb_rd == idx))
            return bus.wb_data;
        else
            return rf[idx[IDX_W-1:0]];
    endfunction

    assign rs1_val = read_reg(rs1);
    assign rs2_val = read_reg(rs2);

    always_ff @(posedge clk) begin
        // NOTE: the register file is cleared on reset because software may
        // rely on every register reading 0 out of reset; the loop costs a
        // reset mux per bit, which a plain RAM macro would not accept.
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (bus.wb_load && (bus.wb_rd != 5'd0) && in_range(bus.wb_rd)) begin
            rf[bus.wb_rd[IDX_W-1:0]] <= bus.wb_data;
        end
    end

    // ---------------- hazard detection and handshake ----------------
    logic out_is_load;
    logic rs1_used;
    logic rs2_used;
    logic advance;
    logic hazard;

    assign rs1_used = !((opcode == OPC_LUI) || (opcode == OPC_AUIPC) || (opcode == OPC_JAL));
    assign rs2_used = (opcode == OPC_BRANCH) || (opcode == OPC_STORE) || (opcode == OPC_OP);
    assign advance  = !bus.regs_out.valid || bus.ex_ready;
    assign hazard   = LOAD_USE_STALL && bus.regs_out.valid && out_is_load &&
                      (bus.regs_out.rd != 5'd0) && bus.if_valid &&
                      ((rs1_used && (rs1 == bus.regs_out.rd)) ||
                       (rs2_used && (rs2 == bus.regs_out.rd)));

    // Deliberately free of wb_*: the handshake never waits on write-back.
    assign bus.id_ready = bus.flush || (advance && !hazard);

    // ---------------- pipeline register ----------------
    always_ff @(posedge clk) begin
        // NOTE: state is written with <= so every flop samples the pre-edge
        // values; a blocking = here would leak this cycle's update into reads.
        if (rst) begin
            bus.regs_out    <= '0;
            out_is_load     <= 1'b0;
            bus.stall_count <= '0;
        end else if (bus.flush) begin
            bus.regs_out <= '0;
            out_is_load  <= 1'b0;
        end else if (advance) begin
            if (hazard) begin
                bus.regs_out <= '0;
                out_is_load  <= 1'b0;
                if (bus.stall_count != '1) bus.stall_count <= bus.stall_count + 32'd1;
            end else begin
                bus.regs_out.valid                <= bus.if_valid;
                bus.regs_out.pc                   <= bus.if_pc;
                bus.regs_out.instr                <= instr;
                bus.regs_out.opcode               <= opcode;
                bus.regs_out.rd                   <= rd;
                bus.regs_out.funct3               <= funct3;
                bus.regs_out.rs1                  <= rs1;
                bus.regs_out.rs2                  <= rs2;
                bus.regs_out.funct7               <= funct7;
                bus.regs_out.i_imm                <= i_imm;
                bus.regs_out.s_imm                <= s_imm;
                bus.regs_out.b_imm                <= b_imm;
                bus.regs_out.u_imm                <= u_imm;
                bus.regs_out.j_imm                <= j_imm;
                bus.regs_out.rs1_val              <= rs1_val;
                bus.regs_out.rs2_val              <= rs2_val;
                bus.regs_out.ctrl.reg_write       <= reg_write;
                bus.regs_out.ctrl.mem_read        <= mem_read;
                bus.regs_out.ctrl.mem_write       <= mem_write;
                bus.regs_out.ctrl.branch          <= branch;
                bus.regs_out.ctrl.jump            <= jump;
                bus.regs_out.ctrl.alu_src_imm     <= alu_src_imm;
                bus.regs_out.ctrl.alu_src_pc      <= alu_src_pc;
                bus.regs_out.ctrl.imm_sel         <= imm_sel;
                bus.regs_out.ctrl.alu_op          <= alu_op;
                bus.regs_out.ctrl.illegal         <= illegal;
                bus.regs_out.alu                  <= 32'd0;
                bus.regs_out.br                   <= 1'b0;
                out_is_load                       <= bus.if_valid && (opcode == OPC_LOAD);
            end
        end
    end

endmodule

// File: tb/tb_decode_hazard_stage.sv
// Directed bench for decode_hazard_stage: default build, a no-bypass build and
// an RV32E (16-register) build all see the same stimulus.
module tb_decode_hazard_stage;

    localparam logic [31:0] I_ADDI_X1_5   = 32'h00500093;
    localparam logic [31:0] I_ADD_X4_X3   = 32'h00318233;
    localparam logic [31:0] I_LW_X5       = 32'h00012283;
    localparam logic [31:0] I_ADD_X6_X5   = 32'h00128333;
    localparam logic [31:0] I_LUI_X5_28   = 32'h000282B7;
    localparam logic [31:0] I_SW_X1_M4    = 32'hFE112E23;
    localparam logic [31:0] I_BEQ_M4      = 32'hFE000EE3;
    localparam logic [31:0] I_ADD_X7_X20  = 32'h000A03B3;

    logic clk = 1'b0;
    logic rst;
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    decode_hazard_stage_if bus();
    decode_hazard_stage_if bus_nb();
    decode_hazard_stage_if bus16();

    assign bus_nb.if_valid = bus.if_valid;
    assign bus_nb.if_instr = bus.if_instr;
    assign bus_nb.if_pc    = bus.if_pc;
    assign bus_nb.ex_ready = bus.ex_ready;
    assign bus_nb.flush    = bus.flush;
    assign bus_nb.wb_load  = bus.wb_load;
    assign bus_nb.wb_rd    = bus.wb_rd;
    assign bus_nb.wb_data  = bus.wb_data;
    assign bus16.if_valid  = bus.if_valid;
    assign bus16.if_instr  = bus.if_instr;
    assign bus16.if_pc     = bus.if_pc;
    assign bus16.ex_ready  = bus.ex_ready;
    assign bus16.flush     = bus.flush;
    assign bus16.wb_load   = bus.wb_load;
    assign bus16.wb_rd     = bus.wb_rd;
    assign bus16.wb_data   = bus.wb_data;

    decode_hazard_stage dut (.clk(clk), .rst(rst), .bus(bus));
    decode_hazard_stage #(.BYPASS(1'b0)) dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));
    decode_hazard_stage #(.NREGS(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_asserts++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input logic [31:0] word, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = word;
        bus.if_pc    = pc;
    endtask

    initial begin
        rst          = 1'b1;
        bus.if_valid = 1'b0;
        bus.if_instr = 32'd0;
        bus.if_pc    = 32'd0;
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b0;
        bus.wb_load  = 1'b0;
        bus.wb_rd    = 5'd0;
        bus.wb_data  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        check("reset_valid", 32'(bus.regs_out.valid), 32'd0);
        check("reset_rd", 32'(bus.regs_out.rd), 32'd0);
        check("reset_stall_count", bus.stall_count, 32'd0);
        check("reset_id_ready", 32'(bus.id_ready), 32'd1);

        // addi x1,x0,5
        offer(I_ADDI_X1_5, 32'h100);
        settle();
        check("addi_id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        check("addi_valid", 32'(bus.regs_out.valid), 32'd1);
        check("addi_rd", 32'(bus.regs_out.rd), 32'd1);
        check("addi_i_imm", bus.regs_out.i_imm, 32'd5);
        check("addi_rs1", 32'(bus.regs_out.rs1), 32'd0);
        check("addi_rs1_val", bus.regs_out.rs1_val, 32'd0);
        check("addi_pc", bus.regs_out.pc, 32'h100);
        check("addi_reg_write", 32'(bus.regs_out.ctrl.reg_write), 32'd1);
        check("addi_alu_zero", bus.regs_out.alu, 32'd0);
        check("addi_br_zero", 32'(bus.regs_out.br), 32'd0);

        // add x4,x3,x3 with a same-cycle write-back to x3
        offer(I_ADD_X4_X3, 32'h104);
        bus.wb_load = 1'b1;
        bus.wb_rd   = 5'd3;
        bus.wb_data = 32'hDEADBEEF;
        tick();
        bus.wb_load = 1'b0;
        check("bypass_rs1_val", bus.regs_out.rs1_val, 32'hDEADBEEF);
        check("bypass_rs2_val", bus.regs_out.rs2_val, 32'hDEADBEEF);
        check("nobypass_rs1_val", bus_nb.regs_out.rs1_val, 32'd0);
        check("nobypass_rs2_val", bus_nb.regs_out.rs2_val, 32'd0);
        check("nobypass_rd", 32'(bus_nb.regs_out.rd), 32'd4);

        // lw x5 then dependent add x6,x5,x1 -> one bubble
        offer(I_LW_X5, 32'h108);
        tick();
        check("lw_mem_read", 32'(bus.regs_out.ctrl.mem_read), 32'd1);
        check("lw_rd", 32'(bus.regs_out.rd), 32'd5);
        offer(I_ADD_X6_X5, 32'h10C);
        settle();
        check("hazard_id_ready", 32'(bus.id_ready), 32'd0);
        tick();
        check("bubble_valid", 32'(bus.regs_out.valid), 32'd0);
        check("bubble_stall_count", bus.stall_count, 32'd1);
        check("after_bubble_id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        check("dep_add_valid", 32'(bus.regs_out.valid), 32'd1);
        check("dep_add_rd", 32'(bus.regs_out.rd), 32'd6);
        check("dep_add_rs1", 32'(bus.regs_out.rs1), 32'd5);
        check("dep_add_stall_count", bus.stall_count, 32'd1);

        // lw x5 then lui x5 (rs1 field happens to be 5 but is unused) -> no stall
        offer(I_LW_X5, 32'h110);
        tick();
        offer(I_LUI_X5_28, 32'h114);
        settle();
        check("lui_id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        check("lui_valid", 32'(bus.regs_out.valid), 32'd1);
        check("lui_u_imm", bus.regs_out.u_imm, 32'h00028000);
        check("lui_stall_count", bus.stall_count, 32'd1);

        // execute back-pressure for three cycles; x2 written mid-stall
        offer(I_SW_X1_M4, 32'h118);
        bus.ex_ready = 1'b0;
        bus.wb_load  = 1'b1;
        bus.wb_rd    = 5'd2;
        bus.wb_data  = 32'h40;
        settle();
        check("stall_id_ready_0", 32'(bus.id_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            bus.wb_load = 1'b0;
            check("stall_valid", 32'(bus.regs_out.valid), 32'd1);
            check("stall_opcode", 32'(bus.regs_out.opcode), 32'h37);
            check("stall_u_imm", bus.regs_out.u_imm, 32'h00028000);
            check("stall_pc", bus.regs_out.pc, 32'h114);
            check("stall_id_ready", 32'(bus.id_ready), 32'd0);
        end
        bus.ex_ready = 1'b1;
        settle();
        check("release_id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        check("sw_opcode", 32'(bus.regs_out.opcode), 32'h23);
        check("sw_s_imm", bus.regs_out.s_imm, 32'hFFFFFFFC);
        check("sw_rs1_val", bus.regs_out.rs1_val, 32'h40);
        check("sw_mem_write", 32'(bus.regs_out.ctrl.mem_write), 32'd1);

        // flush during a load-use hazard
        offer(I_LW_X5, 32'h11C);
        tick();
        offer(I_ADD_X6_X5, 32'h120);
        bus.flush = 1'b1;
        settle();
        check("flush_id_ready", 32'(bus.id_ready), 32'd1);
        tick();
        bus.flush = 1'b0;
        check("flush_valid", 32'(bus.regs_out.valid), 32'd0);
        check("flush_stall_count", bus.stall_count, 32'd1);
        offer(I_BEQ_M4, 32'h124);
        tick();
        check("beq_b_imm", bus.regs_out.b_imm, 32'hFFFFFFFC);
        check("beq_branch", 32'(bus.regs_out.ctrl.branch), 32'd1);
        check("beq_valid", 32'(bus.regs_out.valid), 32'd1);

        // register-count limit and x0 writes
        bus.if_valid = 1'b0;
        bus.wb_load  = 1'b1;
        bus.wb_rd    = 5'd20;
        bus.wb_data  = 32'h12345678;
        tick();
        check("idle_valid", 32'(bus.regs_out.valid), 32'd0);
        bus.wb_rd   = 5'd0;
        bus.wb_data = 32'hFFFFFFFF;
        offer(I_ADD_X7_X20, 32'h128);
        tick();
        check("x20_rs1_val_32", bus.regs_out.rs1_val, 32'h12345678);
        check("x0_bypass_rs2_val", bus.regs_out.rs2_val, 32'd0);
        check("x20_rs1_val_16", bus16.regs_out.rs1_val, 32'd0);
        bus.wb_rd   = 5'd20;
        bus.wb_data = 32'hCAFEF00D;
        tick();
        bus.wb_load = 1'b0;
        check("x20_bypass_32", bus.regs_out.rs1_val, 32'hCAFEF00D);
        check("x20_bypass_16", bus16.regs_out.rs1_val, 32'd0);
        check("x20_nobypass", bus_nb.regs_out.rs1_val, 32'h12345678);
        tick();
        check("x0_after_write", bus.regs_out.rs2_val, 32'd0);

        // reset in the middle of a load-use hazard
        offer(I_LW_X5, 32'h12C);
        tick();
        offer(I_ADD_X6_X5, 32'h130);
        settle();
        check("pre_reset_hazard", 32'(bus.id_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.if_valid = 1'b0;
        settle();
        check("mid_reset_valid", 32'(bus.regs_out.valid), 32'd0);
        check("mid_reset_stall_count", bus.stall_count, 32'd0);
        check("mid_reset_id_ready", 32'(bus.id_ready), 32'd1);
        offer(I_ADD_X4_X3, 32'h134);
        tick();
        check("reset_cleared_x3", bus.regs_out.rs1_val, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
